// File: rtl/rmst_to_fifo_tile.sv
// Load tile: splits one tile request into Avalon read bursts of at most BLEN words
// and unpacks the returned XDW-bit beats into DW-bit words for the load FIFO.
module rmst_to_fifo_tile #(
    parameter int AW   = 12,
    parameter int CW   = 6,
    parameter int DW   = 32,
    parameter int XAW  = 32,
    parameter int XDW  = 128,
    parameter int WCNT = XDW / DW,
    parameter int BLEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic [XAW-1:0] param_raddr,
    input  logic [AW-1:0]  param_iolen,
    output logic           load_done,
    output logic           rmst_fixed_location,
    output logic [XAW-1:0] rmst_read_base,
    output logic [CW-1:0]  rmst_read_length,
    output logic           rmst_go,
    input  logic           rmst_done,
    input  logic [XDW-1:0] rmst_user_buffer_data,
    input  logic           rmst_user_data_available,
    output logic           rmst_user_read_buffer,
    output logic [DW-1:0]  load_fifo_data,
    output logic           load_fifo_push,
    input  logic           load_fifo_full
);
    localparam int VW = $clog2(WCNT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

    state_t         state, state_nx;
    logic [XAW-1:0] addr;
    logic [AW-1:0]  rem_cmd, rem_push, blen_cur, need;
    logic [XDW-1:0] beat;
    logic [VW-1:0]  vcnt;
    logic           done_d, first_wait;
    logic           burst_cmpl, push_now, last_word, pop;

    assign blen_cur   = (rem_cmd > AW'(BLEN)) ? AW'(BLEN) : rem_cmd;
    // words still owed by future beats; unaffected by this cycle's push
    assign need       = rem_push - AW'(vcnt);
    assign push_now   = (vcnt != '0) && !load_fifo_full;
    assign last_word  = push_now && (vcnt == VW'(1));
    assign pop        = (state != IDLE) && rmst_user_data_available &&
                        (rem_push > AW'(vcnt)) && ((vcnt == '0) || last_word);
    // the read master's done level may still be stale right after go
    assign burst_cmpl = rmst_done && !done_d && !first_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (load_start) state_nx = (param_iolen != '0) ? ISSUE : DONE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (burst_cmpl) state_nx = (rem_cmd != '0) ? ISSUE : DRAIN;
            DRAIN: if (rem_push == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rmst_fixed_location   = 1'b0;
        rmst_go               = 1'b0;
        rmst_read_base        = '0;
        rmst_read_length      = '0;
        load_done             = 1'b0;
        rmst_user_read_buffer = pop;
        if (state == ISSUE) begin
            rmst_go          = 1'b1;
            rmst_read_base   = addr;
            rmst_read_length = {blen_cur[CW-3:0], 2'b00};
        end
        if (state == DONE) load_done = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr           <= '0;
            rem_cmd        <= '0;
            rem_push       <= '0;
            beat           <= '0;
            vcnt           <= '0;
            done_d         <= 1'b0;
            first_wait     <= 1'b0;
            load_fifo_push <= 1'b0;
            load_fifo_data <= '0;
        end else begin
            done_d     <= rmst_done;
            first_wait <= (state == ISSUE);
            if (state == IDLE && load_start) begin
                addr     <= param_raddr;
                rem_cmd  <= param_iolen;
                rem_push <= param_iolen;
            end else begin
                if (state == ISSUE) begin
                    addr    <= addr + ({{(XAW-AW){1'b0}}, blen_cur} << 2);
                    rem_cmd <= rem_cmd - blen_cur;
                end
                if (push_now) rem_push <= rem_push - AW'(1);
            end
            // a partial final beat keeps only the words still owed
            if (pop) begin
                beat <= rmst_user_buffer_data;
                vcnt <= (need > AW'(WCNT)) ? VW'(WCNT) : need[VW-1:0];
            end else if (push_now) begin
                beat <= beat >> DW;
                vcnt <= vcnt - VW'(1);
            end
            load_fifo_push <= push_now;
            if (push_now) load_fifo_data <= beat[DW-1:0];
        end
    end
endmodule

// File: tb/tb_rmst_to_fifo_tile.sv
// Scoreboard bench for rmst_to_fifo_tile: read-master/memory model, expected words
// and bursts derived from the tile request, monitor compares every push and go.
module tb_rmst_to_fifo_tile;
    localparam int AW = 12, CW = 6, DW = 32, XAW = 32, XDW = 128, WCNT = 4, BLEN = 8;

    logic           clk = 1'b0, rst = 1'b1;
    logic           load_start = 1'b0;
    logic [XAW-1:0] param_raddr = '0;
    logic [AW-1:0]  param_iolen = '0;
    logic           load_done, rmst_fixed_location, rmst_go, rmst_user_read_buffer;
    logic [XAW-1:0] rmst_read_base;
    logic [CW-1:0]  rmst_read_length;
    logic           rmst_done;
    logic [XDW-1:0] rmst_user_buffer_data;
    logic           rmst_user_data_available;
    logic [DW-1:0]  load_fifo_data;
    logic           load_fifo_push;
    logic           load_fifo_full = 1'b0;

    always #5 clk = ~clk;

    rmst_to_fifo_tile #(.AW(AW), .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW), .BLEN(BLEN)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .param_raddr(param_raddr),
        .param_iolen(param_iolen), .load_done(load_done),
        .rmst_fixed_location(rmst_fixed_location), .rmst_read_base(rmst_read_base),
        .rmst_read_length(rmst_read_length), .rmst_go(rmst_go), .rmst_done(rmst_done),
        .rmst_user_buffer_data(rmst_user_buffer_data),
        .rmst_user_data_available(rmst_user_data_available),
        .rmst_user_read_buffer(rmst_user_read_buffer), .load_fifo_data(load_fifo_data),
        .load_fifo_push(load_fifo_push), .load_fifo_full(load_fifo_full)
    );

    int vecs = 0, errs = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, push_cnt = 0, last_push_cyc = 0, pop_cnt = 0;
    int delay_cfg = 1;
    bit rand_full = 0;
    logic full_prev = 1'b0;

    logic [DW-1:0]  exp_q[$];
    logic [XAW-1:0] gb_q[$];
    logic [CW-1:0]  gl_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory contents: distinct value per word address
    function automatic logic [DW-1:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // read master + user buffer model
    logic [XDW-1:0] buf_q[$];
    int tmr = -1, pbeats = 0, go_lag = 0;
    logic [XAW-1:0] pb = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q.delete();
            tmr = -1;
            go_lag = 0;
            rmst_done <= 1'b1;
            rmst_user_data_available <= 1'b0;
            rmst_user_buffer_data <= '0;
        end else begin
            if (rmst_user_read_buffer) begin
                if (buf_q.size() == 0) chk("pop_empty", 1, 0);
                else begin
                    void'(buf_q.pop_front());
                    pop_cnt++;
                end
            end
            // done falls one cycle late, as a real read master's would
            if (go_lag == 1) begin
                rmst_done <= 1'b0;
                go_lag = 0;
            end
            if (rmst_go) begin
                pb = rmst_read_base;
                pbeats = (int'(rmst_read_length) + 15) / 16;
                tmr = delay_cfg;
                go_lag = 1;
            end else if (tmr > 0) begin
                tmr--;
            end else if (tmr == 0) begin
                for (int j = 0; j < pbeats; j++) begin
                    logic [XDW-1:0] b;
                    for (int k = 0; k < WCNT; k++)
                        b[k*DW +: DW] = mem(pb + 32'(16 * j + 4 * k));
                    buf_q.push_back(b);
                end
                rmst_done <= 1'b1;
                tmr = -1;
            end
            rmst_user_data_available <= (buf_q.size() != 0);
            rmst_user_buffer_data <= (buf_q.size() != 0) ? buf_q[0] : '0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_full) load_fifo_full = ($urandom_range(0, 3) == 0);
    end

    // monitor
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (load_fifo_push) begin
                if (full_prev) chk("push_while_full", 1, 0);
                if (exp_q.size() == 0) chk("extra_push", 1, 0);
                else chk("word", load_fifo_data, exp_q.pop_front());
                push_cnt++;
                last_push_cyc = cyc;
            end
            if (rmst_go) begin
                if (gb_q.size() == 0) chk("extra_go", 1, 0);
                else begin
                    chk("go_base", rmst_read_base, gb_q.pop_front());
                    chk("go_len", rmst_read_length, gl_q.pop_front());
                end
            end
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        full_prev = load_fifo_full;
    end

    task automatic start_tile(input logic [31:0] ra, input int n);
        int rem = n;
        logic [31:0] a = ra;
        for (int i = 0; i < n; i++) exp_q.push_back(mem(ra + 32'(4 * i)));
        while (rem > 0) begin
            int l = (rem > BLEN) ? BLEN : rem;
            gb_q.push_back(a);
            gl_q.push_back(CW'(l * 4));
            a += 32'(l * 4);
            rem -= l;
        end
        @(posedge clk); #1;
        param_raddr = ra;
        param_iolen = AW'(n);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic finish_tile(input string name, input int n, input int d0, input int p0);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_words_left"}, exp_q.size(), 0);
        chk({name, "_bursts_left"}, gb_q.size(), 0);
        chk({name, "_beats"}, pop_cnt - p0, (n + WCNT - 1) / WCNT);
    endtask

    task automatic chk_outs_zero(input string name);
        chk({name, "_go"}, rmst_go, 0);
        chk({name, "_push"}, load_fifo_push, 0);
        chk({name, "_done"}, load_done, 0);
        chk({name, "_rdbuf"}, rmst_user_read_buffer, 0);
        chk({name, "_base"}, rmst_read_base, 0);
        chk({name, "_len"}, rmst_read_length, 0);
        chk({name, "_data"}, load_fifo_data, 0);
        chk({name, "_fixed"}, rmst_fixed_location, 0);
    endtask

    initial begin
        int d0, p0, c0, t;
        #1 rst = 1'b0;
        #12 chk_outs_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        // two full bursts, FIFO never full
        delay_cfg = 1; d0 = done_cnt; p0 = pop_cnt;
        start_tile(32'h1000, 16);
        finish_tile("t16", 16, d0, p0);
        chk("t16_done_lat", done_cyc - last_push_cyc, 1);

        // partial final burst and partial final beat
        delay_cfg = 2; d0 = done_cnt; p0 = pop_cnt;
        start_tile(32'h2004, 10);
        finish_tile("t10", 10, d0, p0);

        // FIFO full for 5 cycles mid-beat
        delay_cfg = 1; d0 = done_cnt; p0 = pop_cnt; c0 = push_cnt;
        start_tile(32'h3000, 16);
        t = 0;
        while (push_cnt < c0 + 2 && t < 200) begin @(negedge clk); t++; end
        chk("full_reached", push_cnt >= c0 + 2, 1);
        @(posedge clk); #1 load_fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rdbuf_while_full", rmst_user_read_buffer, 0);
            @(posedge clk); #1;
        end
        load_fifo_full = 1'b0;
        finish_tile("tfull", 16, d0, p0);

        // empty tile
        d0 = done_cnt; p0 = pop_cnt;
        start_tile(32'h4000, 0);
        chk("zero_done", load_done, 1);
        @(posedge clk); #1;
        chk("zero_done_off", load_done, 0);
        repeat (3) @(negedge clk);
        chk("zero_pulses", done_cnt - d0, 1);
        chk("zero_pops", pop_cnt - p0, 0);

        // slow data, ignored second start mid-tile
        delay_cfg = 20; d0 = done_cnt; p0 = pop_cnt;
        start_tile(32'h1000, 16);
        repeat (5) @(posedge clk);
        #1 param_raddr = 32'h5000; param_iolen = AW'(3); load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        finish_tile("tslow", 16, d0, p0);

        // reset mid-tile
        delay_cfg = 2; c0 = push_cnt;
        start_tile(32'h6000, 16);
        t = 0;
        while (push_cnt < c0 + 3 && t < 200) begin @(negedge clk); t++; end
        #2 rst = 1'b0;
        #1 chk_outs_zero("midrst");
        exp_q.delete(); gb_q.delete(); gl_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        d0 = done_cnt; p0 = pop_cnt;
        start_tile(32'h7000, 4);
        finish_tile("tpost", 4, d0, p0);

        // random tiles with random backpressure
        rand_full = 1;
        for (int i = 0; i < 8; i++) begin
            int n = $urandom_range(1, 40);
            delay_cfg = $urandom_range(1, 6);
            d0 = done_cnt; p0 = pop_cnt;
            start_tile(32'($urandom_range(0, 4095)) << 2, n);
            finish_tile("trand", n, d0, p0);
        end
        rand_full = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
